// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller and its result FIFO.
package pattern_scan_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int OFS_W      = 32;

    localparam logic [1:0] ADDR_PAT  = 2'd0;
    localparam logic [1:0] ADDR_WC   = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Index of the lowest set bit (0 when no bit is set).
    function automatic logic [2:0] low_bit_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Config, text stream, matcher and result signals of the pattern scan controller.
interface pattern_scan_ctrl_if;
    logic        cfg_wren;
    logic [1:0]  cfg_addr;
    logic [63:0] cfg_din;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [127:0] win_out;
    logic [63:0] pat_out;
    logic [7:0]  wc_out;
    logic [15:0] match_in;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [15:0] hit_count;

    modport master (
        output cfg_wren, cfg_addr, cfg_din, in_valid, in_data, in_last, match_in, res_ready,
        input  in_ready, win_out, pat_out, wc_out, res_valid, res_data, busy, done, hit_count
    );

    modport slave (
        input  cfg_wren, cfg_addr, cfg_din, in_valid, in_data, in_last, match_in, res_ready,
        output in_ready, win_out, pat_out, wc_out, res_valid, res_data, busy, done, hit_count
    );
endinterface

// File: rtl/pattern_scan_ctrl_result_fifo.sv
// 8 x 32 first-word-fall-through FIFO holding hit offsets; a push into a full FIFO is refused.
module scan_result_fifo
    import pattern_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [OFS_W-1:0] push_data,
    input  logic             pop,
    output logic [OFS_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [OFS_W-1:0] mem_q [FIFO_DEPTH];
    logic [OFS_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign pop_data  = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Streams 64-bit text words through a 16-byte window for an external matcher and
// queues the stream byte offset of every hit in a result FIFO.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pattern_scan_ctrl_if.slave   bus
);
    state_e           state_q, state_d;
    logic [127:0]     window_q, window_d;
    logic [63:0]      pat_q, pat_d;
    logic [7:0]       wc_q, wc_d;
    logic [7:0]       mask_q, mask_d;
    logic [31:0]      word_idx_q, word_idx_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic             last_q, last_d;
    logic             flushing_q, flushing_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             push_s, fifo_full_s, fifo_empty_s;
    logic [OFS_W-1:0] push_data_s;
    logic [2:0]       low_idx_s;
    logic [7:0]       eval_mask_s;
    state_e           exit_s;

    scan_result_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (bus.res_ready),
        .pop_data  (bus.res_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign bus.res_valid = !fifo_empty_s;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_count = hit_cnt_q;
    assign bus.win_out   = window_q;
    assign bus.pat_out   = pat_q;
    assign bus.wc_out    = wc_q;

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        pat_d      = pat_q;
        wc_d       = wc_q;
        mask_d     = mask_q;
        word_idx_d = word_idx_q;
        hit_cnt_d  = hit_cnt_q;
        last_d     = last_q;
        flushing_d = flushing_q;
        push_s     = 1'b0;

        low_idx_s   = low_bit_idx(mask_q);
        push_data_s = ((word_idx_q - 32'd2) << 3) + {29'd0, low_idx_s};

        for (int k = 0; k < 8; k++) eval_mask_s[k] = bus.match_in[15-k];
        // During flush only start 0 lies wholly in real data; on the first word the older half is empty.
        if (flushing_q) begin
            eval_mask_s = eval_mask_s & 8'h01;
        end else if (word_idx_q == 32'd1) begin
            eval_mask_s = 8'h00;
        end else begin
            eval_mask_s = eval_mask_s;
        end

        if (last_q && !flushing_q) begin
            exit_s = ST_FLUSH;
        end else if (flushing_q) begin
            exit_s = ST_DONE;
        end else begin
            exit_s = ST_SCAN;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_wren) begin
                    case (bus.cfg_addr)
                        ADDR_PAT: pat_d = bus.cfg_din;
                        ADDR_WC:  wc_d  = bus.cfg_din[7:0];
                        ADDR_CTRL: begin
                            if (bus.cfg_din[0]) begin
                                hit_cnt_d  = 16'd0;
                                word_idx_d = 32'd0;
                                window_d   = 128'd0;
                                mask_d     = 8'd0;
                                last_d     = 1'b0;
                                flushing_d = 1'b0;
                                state_d    = ST_SCAN;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.in_valid && in_ready_q) begin
                    window_d   = {window_q[63:0], bus.in_data};
                    last_d     = bus.in_last;
                    word_idx_d = word_idx_q + 32'd1;
                    state_d    = ST_EVAL;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_EVAL: begin
                mask_d  = eval_mask_s;
                state_d = (eval_mask_s != 8'd0) ? ST_DRAIN : exit_s;
            end
            ST_DRAIN: begin
                if (!fifo_full_s) begin
                    push_s = 1'b1;
                    mask_d = mask_q & ~(8'd1 << low_idx_s);
                    if (hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end else begin
                        hit_cnt_d = hit_cnt_q;
                    end
                    state_d = (mask_d == 8'd0) ? exit_s : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                window_d   = {window_q[63:0], 64'd0};
                flushing_d = 1'b1;
                word_idx_d = word_idx_q + 32'd1;
                state_d    = ST_EVAL;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_SCAN);
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            window_q   <= '0;
            pat_q      <= '0;
            wc_q       <= '0;
            mask_q     <= '0;
            word_idx_q <= '0;
            hit_cnt_q  <= '0;
            last_q     <= 1'b0;
            flushing_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            pat_q      <= pat_d;
            wc_q       <= wc_d;
            mask_q     <= mask_d;
            word_idx_q <= word_idx_d;
            hit_cnt_q  <= hit_cnt_d;
            last_q     <= last_d;
            flushing_q <= flushing_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-002 SHALL have cfg_wren in 1 (config write strobe), cfg_addr in 2 (0=pattern, 1=wildcard, 2=control), cfg_din in 64 (config data).
REQ-003 SHALL have in_valid in 1, in_data in 64 (8 text bytes, byte 0 = [63:56]), in_last in 1, in_ready out 1.
REQ-004 SHALL have win_out out 128, pat_out out 64, wc_out out 8, all driving an external pattern_matcher.
REQ-005 SHALL have match_in in 16 from that matcher; bit (15-k) set = match starting at window byte k, byte 0 = win_out[127:120].
REQ-006 SHALL have res_valid out 1, res_data out 32 (stream byte offset of a hit), res_ready in 1.
REQ-007 SHALL have busy out 1, done out 1 (one-cycle pulse), hit_count out 16.
REQ-008 SHALL use constants FIFO_DEPTH = 8 and ADDR_PAT/ADDR_WC/ADDR_CTRL = 0/1/2.

Function
REQ-009 SHALL load pattern from cfg_din[63:0] and wildcard from cfg_din[7:0] on cfg_wren in IDLE; these writes SHALL be ignored while busy.
REQ-010 SHALL start a scan on a cfg write to ADDR_CTRL with cfg_din[0]=1 in IDLE: clear hit_count, word index and window; ignore start while busy.
REQ-011 SHALL implement states IDLE, SCAN, EVAL, DRAIN, FLUSH, DONE; busy = state not in {IDLE, DONE}.
REQ-012 SHALL assert in_ready only in SCAN; on in_valid&&in_ready: window <= {window[63:0], in_data}, latch in_last, increment word index, go to EVAL.
REQ-013 In EVAL SHALL capture mask[k] = match_in[15-k], k=0..7; mask SHALL be forced to 0 for the first word of a stream (older half invalid).
REQ-014 Hit offset SHALL be (word_index-2)*8 + k, 32-bit, counted from stream byte 0.
REQ-015 From EVAL: mask nonzero -> DRAIN; else latched last and not flushing -> FLUSH; else flushing -> DONE; else -> SCAN.
REQ-016 In DRAIN SHALL push the lowest set mask bit's offset into the result FIFO, one per cycle, and clear that bit; when the FIFO is full it SHALL stall without dropping.
REQ-017 When the mask empties, DRAIN SHALL follow the same exits as EVAL in REQ-015.
REQ-018 FLUSH SHALL shift a zero word into the window, set flushing, and go to EVAL; mask in that EVAL SHALL keep only k=0 (only fully-valid start offset).
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE; the FIFO SHALL remain readable in IDLE.
REQ-020 hit_count SHALL increment per pushed hit and saturate at 0xFFFF.
REQ-021 Result FIFO SHALL be first-word-fall-through: res_valid = not empty, pop on res_valid&&res_ready; simultaneous push and pop when full SHALL stall the push and allow the pop.
REQ-022 pat_out/wc_out SHALL be the stored registers; win_out SHALL be the window register; match_in SHALL be sampled only in EVAL (one cycle after shift).

Reset
REQ-023 rst SHALL, at any time including mid-scan, force IDLE and clear window, pattern, wildcard, mask, word index, hit_count, flags and FIFO.
REQ-024 After rst, all outputs SHALL be 0: in_ready, res_valid, res_data, busy, done, hit_count, win_out, pat_out, wc_out.

Structure
REQ-025 SHALL place the state enum, FIFO_DEPTH, config address constants and offset width in package pattern_scan_pkg.
REQ-026 SHALL instantiate one sub-module, scan_result_fifo (8 x 32 synchronous FWFT FIFO, full/empty flags).
REQ-027 SHALL NOT instantiate pattern_matcher; the top level connects the two blocks.

Verification
REQ-028 Pattern "ABCDEFGH", wildcard 0, stream "xxABCDEF","GHyyyyyy" last -> one hit, res_data=2, hit_count=1, done pulse.
REQ-029 Pattern "ABCDEFGH", wildcard 0x01 (byte 7 don't-care), stream "ABCDEFGZ" single word last -> flush hit, res_data=0.
REQ-030 Pattern all-wildcard 0xFF, 2-word stream -> hits 0..7 then flush hit 8, i.e. 9 hits; pushes stall while FIFO full with res_ready=0, and no loss when res_ready later rises.
REQ-031 rst asserted mid-DRAIN with 3 pending hits -> next cycle IDLE, res_valid=0, hit_count=0, in_ready=0.
REQ-032 Start or pattern write while busy -> ignored: pat_out unchanged, scan result identical to an undisturbed run.
